rr_mux_sched: RTL
=================

Name: rr_mux_sched

Overview:
- Round-robin scheduler that shares the 4:1 selection mux (4 lanes, 2-bit select) between four requesters.
- Arbitrates requests and drives the mux select plus a one-hot grant.
- Presents the selected lane downstream with a valid/ready handshake.
- Bounds each grant to a burst limit so no requester can starve the others.

Parameters:
- DW, 1: data width per lane. 1 matches the existing 1-bit mux lanes.
- MAX_BURST, 4: maximum accepted transfers per grant while another requester is waiting. Must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per lane. Held high until the lane's last transfer is accepted.
- data  input  4*DW  lane data. Lane i occupies bits [i*DW +: DW]. Stable while req[i] is high and not yet accepted.
- out_ready  input  1  downstream ready.
- sel  output  2  registered mux select; index of the current/last winner.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- out_valid  output  1  selected lane presenting data.
- out_data  output  DW  data of lane sel.
- busy  output  1  high in state GRANT.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, sel=2'd0, gnt=4'b0000, burst count=0, busy=0.
  - Pointer last=3, so lane 0 has first priority after reset.
  - out_valid=0 while reset is asserted.
- Arbitration function win(mask):
  - First set bit of mask, searching last+1, last+2, last+3, last (mod 4).
  - Wrap-around is required: last=3 searches 0,1,2,3.
- States: IDLE, GRANT.
- IDLE:
  - req==0: stay, all outputs held.
  - req≠0: at the next edge, sel=win(req), gnt=1<<win, last=win, count=0, state=GRANT.
  - Latency: req rise to gnt rise is exactly 1 cycle.
- GRANT, combinational outputs:
  - out_valid = req[sel].
  - out_data = data[sel] (mux output).
  - Accept = out_valid & out_ready.
- GRANT transitions, evaluated each edge in priority order:
  1. req[sel]==0 (release): if other=req & ~gnt is nonzero, grant win(other) directly with no bubble and count=0. Else state=IDLE and gnt=0; sel is held.
  2. Accept and count==MAX_BURST-1: if other≠0, rotate to win(other) and count=0. Else keep the grant and set count=0.
  3. Accept with count below the limit: count+1.
  4. No accept (backpressure): hold everything; count unchanged.
- A release in the same cycle as the final accept is allowed. Downstream sees exactly the accepted beats.
- Count width is max(1, clog2(MAX_BURST)). With MAX_BURST=1, a contended grant rotates after every accept.
- A lane is never granted while its req is low. gnt is always one-hot or zero, never multi-hot.
- Simultaneous requests are resolved only by the rotating pointer. No fixed priority exists except immediately after reset.
- Reset mid-transfer:
  - The in-flight beat is dropped and outputs go to reset values immediately.
  - After rst_n rises, arbitration restarts from lane 0 priority.
- out_valid never rises without gnt. Once high, it stays high until accepted unless the requester withdraws, which is illegal and not required to be detected.

Test Plan:
- Reset check: rst_n=0 → sel=0, gnt=0000, out_valid=0, busy=0. Release, then req=0100 → gnt=0100 and sel=2 one cycle later.
- Burst limit: req=0011, out_ready=1, MAX_BURST=4 → lane0 gets exactly 4 accepts, lane1 gets 4, then lane0. The gnt sequence alternates 0001/0010 every 4 beats.
- Round-robin wrap: lane3 granted, it releases, req=1001 → next gnt=0001 (wraps from 3 to 0), not 1000.
- Backpressure: lane2 granted with count=3, out_ready=0 for 5 cycles → gnt, sel, out_data stable and count stays 3. The first accept after that forces rotation to the pending lane.
- Release with no bubble: lane1 drops req while req[3]=1 → gnt goes 0010→1000 in one edge. Alone with no other requests, lane1 release → IDLE, gnt=0000, sel stays 1.
- Async reset mid-burst: rst_n low between edges while out_valid=1 → gnt=0000 and out_valid=0 with no clock edge. After release with req=1111, the first gnt is 0001.

Source files
------------

// File: rtl/rr_mux_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_mux_sched: round-robin, burst-limited scheduler for a 4:1 mux      |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module rr_mux_sched #(
   parameter int DW        = 1,
   parameter int MAX_BURST = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [3:0]      req,
   input  logic [4*DW-1:0] data,
   input  logic            out_ready,
   output logic [1:0]      sel,
   output logic [3:0]      gnt,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic            busy
);

   localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CW-1:0] C_CNT_LAST = CW'(MAX_BURST - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [1:0]    r_sel,   w_sel_nxt;
   logic [1:0]    r_last,  w_last_nxt;
   logic [3:0]    r_gnt,   w_gnt_nxt;
   logic [CW-1:0] r_cnt,   w_cnt_nxt;
   logic [3:0]    w_other;
   logic          w_accept;
   logic [1:0]    w_win_req;
   logic [1:0]    w_win_oth;
   logic [DW-1:0] w_lane [4];

   // First set bit of mask searching last+1 .. last+4 (mod 4).
   function automatic logic [1:0] f_win(input logic [3:0] mask, input logic [1:0] last);
      logic [1:0] idx;
      f_win = last;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (mask[idx]) f_win = idx;
      end
   endfunction

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane[gi] = data[gi*DW +: DW];
      end
   endgenerate

   assign w_other   = req & ~r_gnt;
   assign w_win_req = f_win(req, r_last);
   assign w_win_oth = f_win(w_other, r_last);
   assign out_valid = (r_state == S_GRANT) & req[r_sel];
   assign out_data  = w_lane[r_sel];
   assign w_accept  = out_valid & out_ready;
   assign sel       = r_sel;
   assign gnt       = r_gnt;
   assign busy      = (r_state == S_GRANT);

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_last_nxt  = r_last;
      w_gnt_nxt   = r_gnt;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (|req) begin
               w_state_nxt = S_GRANT;
               w_sel_nxt   = w_win_req;
               w_last_nxt  = w_win_req;
               w_gnt_nxt   = 4'b0001 << w_win_req;
               w_cnt_nxt   = '0;
            end
         end
         S_GRANT: begin
            if (!req[r_sel]) begin
               if (|w_other) begin
                  w_sel_nxt  = w_win_oth;
                  w_last_nxt = w_win_oth;
                  w_gnt_nxt  = 4'b0001 << w_win_oth;
                  w_cnt_nxt  = '0;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = 4'b0000;
               end
            end else if (w_accept && (r_cnt == C_CNT_LAST)) begin
               // Burst limit reached: hand over only if someone else waits.
               w_cnt_nxt = '0;
               if (|w_other) begin
                  w_sel_nxt  = w_win_oth;
                  w_last_nxt = w_win_oth;
                  w_gnt_nxt  = 4'b0001 << w_win_oth;
               end
            end else if (w_accept) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_sel   <= 2'd0;
         r_last  <= 2'd3;
         r_gnt   <= 4'b0000;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_last  <= w_last_nxt;
         r_gnt   <= w_gnt_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

endmodule
`default_nettype wire
